// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output conditioning path.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_OUT_WIDTH  = 16;

  // Payload is sized for the widest legal output; narrower outputs are sign-extended.
  localparam int SHAPED_W = DEF_DATA_WIDTH;

  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [SHAPED_W-1:0] data;
    logic                last;
  } shaped_t;

  // A decimation setting of 0 behaves like 1 (keep every sample).
  function automatic logic [3:0] decim_eff(input logic [3:0] d);
    return (d == 4'd0) ? 4'd1 : d;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready buffer (main + skid register) with a registered in_ready.
module axis_skid_buf
  import fir_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  shaped_t in_data,
  output logic    in_ready,
  output logic    out_valid,
  output shaped_t out_data,
  input  logic    out_ready
);

  logic    main_valid, main_valid_next;
  logic    skid_valid, skid_valid_next;
  logic    ready_reg;
  shaped_t main_data, main_data_next;
  shaped_t skid_data, skid_data_next;
  logic    push, pop;

  assign push = in_valid && ready_reg;
  assign pop  = main_valid && out_ready;

  always_comb begin
    main_valid_next = main_valid;
    main_data_next  = main_data;
    skid_valid_next = skid_valid;
    skid_data_next  = skid_data;
    // ready_reg mirrors an empty skid, so a push never coincides with a full skid.
    if (skid_valid) begin
      if (pop) begin
        main_data_next  = skid_data;
        skid_valid_next = 1'b0;
      end
    end else if (push) begin
      if (!main_valid || pop) begin
        main_valid_next = 1'b1;
        main_data_next  = in_data;
      end else begin
        skid_valid_next = 1'b1;
        skid_data_next  = in_data;
      end
    end else if (pop) begin
      main_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_reg  <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_next;
      skid_valid <= skid_valid_next;
      ready_reg  <= !skid_valid_next;
      main_data  <= main_data_next;
      skid_data  <= skid_data_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/fir_out_shaper.sv
// Round/shift, saturate-or-wrap and decimate FIR results onto a skid-buffered AXI-Stream.
// Define FIR_OUT_SAT_EN for clamping and saturation counting; otherwise the output wraps.
module fir_out_shaper
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pOUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pOUT_WIDTH-1:0]  sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  input  logic [4:0]             cfg_shift,
  input  logic [3:0]             cfg_decim,
  output logic                   frame_done,
  output logic [15:0]            sat_cnt
);

  localparam int RW = pDATA_WIDTH + 1;

  logic       accept, frame_start, forward;
  logic       in_frame_reg;
  logic [4:0] shift_reg, shift_cur;
  logic [3:0] decim_reg, decim_cur;
  logic [3:0] phase_reg, phase_cur, phase_next;

  assign accept      = ss_tvalid && ss_tready;
  assign frame_start = accept && !in_frame_reg;

  // The frame's first beat uses the live config; later beats use the latched copy.
  always_comb begin
    shift_cur  = frame_start ? cfg_shift : shift_reg;
    decim_cur  = frame_start ? decim_eff(cfg_decim) : decim_reg;
    phase_cur  = frame_start ? 4'd0 : phase_reg;
    forward    = (phase_cur == 4'd0) || ss_tlast;
    phase_next = (phase_cur == decim_cur - 4'd1) ? 4'd0 : phase_cur + 4'd1;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      in_frame_reg <= 1'b0;
      shift_reg    <= 5'd0;
      decim_reg    <= 4'd1;
      phase_reg    <= 4'd0;
    end else if (accept) begin
      in_frame_reg <= !ss_tlast;
      phase_reg    <= phase_next;
      if (frame_start) begin
        shift_reg <= cfg_shift;
        decim_reg <= decim_eff(cfg_decim);
      end
    end
  end

  logic signed [pDATA_WIDTH:0]  x_ext, rnd, r;
  logic signed [pOUT_WIDTH-1:0] shaped;
  logic                         sat;

  always_comb begin
    x_ext = {ss_tdata[pDATA_WIDTH-1], ss_tdata};
    rnd   = (shift_cur == 5'd0) ? '0 : (RW'(1) << (shift_cur - 5'd1));
    r     = (x_ext + rnd) >>> shift_cur;
  end

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [pDATA_WIDTH:0] R_MAX =
    {{(pDATA_WIDTH-pOUT_WIDTH+2){1'b0}}, {(pOUT_WIDTH-1){1'b1}}};
  localparam logic signed [pDATA_WIDTH:0] R_MIN =
    {{(pDATA_WIDTH-pOUT_WIDTH+2){1'b1}}, {(pOUT_WIDTH-1){1'b0}}};

  logic        sat_hi, sat_lo;
  logic [15:0] sat_cnt_reg;

  always_comb begin
    sat_hi = r > R_MAX;
    sat_lo = r < R_MIN;
    sat    = sat_hi || sat_lo;
    if (sat_hi)      shaped = R_MAX[pOUT_WIDTH-1:0];
    else if (sat_lo) shaped = R_MIN[pOUT_WIDTH-1:0];
    else             shaped = r[pOUT_WIDTH-1:0];
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sat_cnt_reg <= 16'd0;
    end else if (accept && forward) begin
      if (frame_start)                          sat_cnt_reg <= {15'd0, sat};
      else if (sat && sat_cnt_reg != 16'hFFFF)  sat_cnt_reg <= sat_cnt_reg + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_reg;
`else
  always_comb begin
    sat    = 1'b0;
    shaped = r[pOUT_WIDTH-1:0];
  end

  assign sat_cnt = 16'd0;
`endif

  shaped_t in_beat, out_beat;

  always_comb begin
    in_beat.data = shaped;   // sign-extends into the wider payload field
    in_beat.last = ss_tlast;
  end

  axis_skid_buf u_skid (
    .clk       (axis_clk),
    .rst_n     (axis_rst_n),
    .in_valid  (ss_tvalid && forward),
    .in_data   (in_beat),
    .in_ready  (ss_tready),
    .out_valid (sm_tvalid),
    .out_data  (out_beat),
    .out_ready (sm_tready)
  );

  assign sm_tdata = out_beat.data[pOUT_WIDTH-1:0];
  assign sm_tlast = out_beat.last;

  logic frame_done_reg;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) frame_done_reg <= 1'b0;
    else             frame_done_reg <= sm_tvalid && sm_tready && sm_tlast;
  end

  assign frame_done = frame_done_reg;

  // Bits intentionally left unobserved: upper rounding bits and payload extension.
  logic unused_bits;
  assign unused_bits = ^{r, sat, out_beat.data};

endmodule
